// File: rtl/wb_ram_arbiter.sv
// Two-master Wishbone-classic arbiter sharing the single-port RAM between fetch (m0) and data (m1).
// Define WB_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default build is fixed m0 priority.
module wb_ram_arbiter #(
  parameter int ADR_W = 30,
  parameter int DAT_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               m0_stb_i,
  input  logic               m0_we_i,
  input  logic [DAT_W/8-1:0] m0_sel_i,
  input  logic [ADR_W-1:0]   m0_adr_i,
  input  logic [DAT_W-1:0]   m0_dat_i,
  output logic [DAT_W-1:0]   m0_dat_o,
  output logic               m0_ack_o,
  input  logic               m1_stb_i,
  input  logic               m1_we_i,
  input  logic [DAT_W/8-1:0] m1_sel_i,
  input  logic [ADR_W-1:0]   m1_adr_i,
  input  logic [DAT_W-1:0]   m1_dat_i,
  output logic [DAT_W-1:0]   m1_dat_o,
  output logic               m1_ack_o,
  output logic               s_stb_o,
  output logic               s_we_o,
  output logic [DAT_W/8-1:0] s_sel_o,
  output logic [ADR_W-1:0]   s_adr_o,
  output logic [DAT_W-1:0]   s_dat_o,
  input  logic [DAT_W-1:0]   s_dat_i,
  input  logic               s_ack_i,
  output logic [1:0]         gnt_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       last_r;
  logic       last_next;
  logic       pick_m1;
  logic       in_gnt0;
  logic       in_gnt1;

  assign in_gnt0 = (state == GNT0);
  assign in_gnt1 = (state == GNT1);

  // Only a tie between both masters depends on the arbitration policy.
  always_comb begin
`ifdef WB_ARB_ROUND_ROBIN_EN
    if (m0_stb_i && m1_stb_i)
      pick_m1 = ~last_r;
    else
      pick_m1 = m1_stb_i;
`else
    pick_m1 = m1_stb_i & ~m0_stb_i;
`endif
  end

  always_comb begin
    state_next = state;
    last_next  = last_r;
    case (state)
      IDLE: begin
        if (m0_stb_i || m1_stb_i)
          state_next = pick_m1 ? GNT1 : GNT0;
      end
      GNT0: begin
        if (s_ack_i) begin
          state_next = IDLE;
          last_next  = 1'b0;
        end else if (!m0_stb_i) begin
          state_next = IDLE;
        end
      end
      GNT1: begin
        if (s_ack_i) begin
          state_next = IDLE;
          last_next  = 1'b1;
        end else if (!m1_stb_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Every grant returns through IDLE so the RAM always sees stb low between cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      last_r <= 1'b1;
    end else begin
      state  <= state_next;
      last_r <= last_next;
    end
  end

  always_comb begin
    if (in_gnt1) begin
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end else begin
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
    end
  end

  assign s_stb_o  = (in_gnt0 & m0_stb_i) | (in_gnt1 & m1_stb_i);
  assign m0_ack_o = in_gnt0 & s_ack_i;
  assign m1_ack_o = in_gnt1 & s_ack_i;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign gnt_o    = {in_gnt1, in_gnt0};

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Randomized bench for wb_ram_arbiter with a RAM stand-in and a transaction-level arbitration model.
// Expectations follow WB_ARB_ROUND_ROBIN_EN when the design is built with it.
module tb_wb_ram_arbiter;
  localparam int ADR_W = 30;
  localparam int DAT_W = 32;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [4:0]  adr;
    logic [31:0] dat;
  } op_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        m0_stb_i, m0_we_i, m1_stb_i, m1_we_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic [ADR_W-1:0] m0_adr_i, m1_adr_i;
  logic [31:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m1_ack_o;
  logic        s_stb_o, s_we_o, s_ack_i;
  logic [3:0]  s_sel_o;
  logic [ADR_W-1:0] s_adr_o;
  logic [31:0] s_dat_o, s_dat_i;
  logic [1:0]  gnt_o;

  int checks = 0;
  int failures = 0;
  int ref_last = 1;
  logic [31:0] ref_mem [32];
  logic [31:0] last_rd_data;
  op_t ops0[$];
  op_t ops1[$];

  always #5 clk_i = ~clk_i;

  wb_ram_arbiter #(.ADR_W(ADR_W), .DAT_W(DAT_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i),
    .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i),
    .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  // RAM stand-in: writes ack combinationally, reads ack one cycle later with registered data.
  logic [31:0] ram_mem [32] = '{default: 32'h0};
  logic        rd_ack = 1'b0;
  logic [31:0] rd_dat = 32'h0;
  assign s_ack_i = s_we_o ? s_stb_o : rd_ack;
  assign s_dat_i = rd_dat;

  always @(posedge clk_i) begin
    rd_ack <= s_stb_o & ~s_we_o & ~rd_ack;
    rd_dat <= ram_mem[s_adr_o[4:0]];
    if (s_stb_o && s_we_o)
      for (int b = 0; b < 4; b++)
        if (s_sel_o[b]) ram_mem[s_adr_o[4:0]][8*b +: 8] <= s_dat_o[8*b +: 8];
  end

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  function automatic op_t mk_op(input logic we, input logic [3:0] sel, input logic [4:0] adr, input logic [31:0] dat);
    op_t o;
    o.we = we; o.sel = sel; o.adr = adr; o.dat = dat;
    return o;
  endfunction

  function automatic op_t rand_op();
    return mk_op(1'($urandom_range(0, 1)), 4'($urandom), 5'($urandom), $urandom);
  endfunction

  task automatic drive_master(input int m, input logic stb, input op_t op);
    if (m == 0) begin
      m0_stb_i = stb; m0_we_i = op.we; m0_sel_i = op.sel;
      m0_adr_i = {25'd0, op.adr}; m0_dat_i = op.dat;
    end else begin
      m1_stb_i = stb; m1_we_i = op.we; m1_sel_i = op.sel;
      m1_adr_i = {25'd0, op.adr}; m1_dat_i = op.dat;
    end
  endtask

  // Each master works through its queue, holding stb until acked; the model predicts who is acked when.
  task automatic apply_stimulus(input string tag);
    int n0, n1, i0, i1, done0, done1, j0, j1, g, w, a, nmin;
    logic ack0p, ack1p, prev_ack;
    op_t op;
    int exp_m[$]; int exp_c[$]; logic [31:0] exp_d[$]; logic exp_rd[$];
    int act_m[$]; int act_c[$]; logic [31:0] act_d[$]; logic [1:0] act_g[$];
    n0 = ops0.size(); n1 = ops1.size();
    j0 = 0; j1 = 0; g = 1;
    while (j0 < n0 || j1 < n1) begin
      if (j0 < n0 && j1 < n1) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
        w = (ref_last == 1) ? 0 : 1;
`else
        w = 0;
`endif
      end else begin
        w = (j0 < n0) ? 0 : 1;
      end
      if (w == 0) begin op = ops0[j0]; j0++; end
      else begin op = ops1[j1]; j1++; end
      a = g + (op.we ? 0 : 1);
      exp_m.push_back(w); exp_c.push_back(a); exp_rd.push_back(!op.we);
      if (op.we) begin
        for (int b = 0; b < 4; b++)
          if (op.sel[b]) ref_mem[op.adr][8*b +: 8] = op.dat[8*b +: 8];
        exp_d.push_back(32'h0);
      end else begin
        exp_d.push_back(ref_mem[op.adr]);
      end
      ref_last = w;
      g = a + 2;
    end

    i0 = 0; i1 = 0; done0 = 0; done1 = 0;
    ack0p = 1'b0; ack1p = 1'b0; prev_ack = 1'b0;
    @(posedge clk_i); #1;
    drive_master(0, n0 > 0, (n0 > 0) ? ops0[0] : rand_op());
    drive_master(1, n1 > 0, (n1 > 0) ? ops1[0] : rand_op());
    for (int c = 1; c <= 80 && (done0 < n0 || done1 < n1); c++) begin
      @(posedge clk_i); #1;
      if (ack0p) begin i0++; drive_master(0, i0 < n0, (i0 < n0) ? ops0[i0] : rand_op()); end
      if (ack1p) begin i1++; drive_master(1, i1 < n1, (i1 < n1) ? ops1[i1] : rand_op()); end
      @(negedge clk_i);
      if (prev_ack) check_output({tag, "_idle_gap"}, {30'd0, gnt_o}, 32'h0);
      prev_ack = m0_ack_o | m1_ack_o;
      ack0p = m0_ack_o; ack1p = m1_ack_o;
      if (m0_ack_o) begin
        act_m.push_back(0); act_c.push_back(c); act_d.push_back(m0_dat_o); act_g.push_back(gnt_o); done0++;
      end
      if (m1_ack_o) begin
        act_m.push_back(1); act_c.push_back(c); act_d.push_back(m1_dat_o); act_g.push_back(gnt_o); done1++;
      end
    end
    @(posedge clk_i); #1;
    drive_master(0, 1'b0, rand_op());
    drive_master(1, 1'b0, rand_op());
    @(negedge clk_i);
    check_output({tag, "_end_idle"}, {30'd0, gnt_o}, 32'h0);
    check_output({tag, "_done"}, {31'd0, (done0 >= n0 && done1 >= n1)}, 32'd1);
    check_output({tag, "_ack_count"}, act_m.size(), exp_m.size());
    nmin = (act_m.size() < exp_m.size()) ? act_m.size() : exp_m.size();
    for (int k = 0; k < nmin; k++) begin
      check_output({tag, "_master"}, act_m[k], exp_m[k]);
      check_output({tag, "_ack_cycle"}, act_c[k], exp_c[k]);
      check_output({tag, "_gnt"}, {30'd0, act_g[k]}, (exp_m[k] == 0) ? 32'd1 : 32'd2);
      if (exp_rd[k]) begin
        check_output({tag, "_rd_data"}, act_d[k], exp_d[k]);
        last_rd_data = act_d[k];
      end
    end
    ops0.delete();
    ops1.delete();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int k = 0; k < 32; k++) ref_mem[k] = 32'h0;
    last_rd_data = 32'h0;
    rst_ni = 1'b0;
    drive_master(0, 1'b1, mk_op(1'b0, 4'hF, 5'd3, 32'h0));
    drive_master(1, 1'b1, mk_op(1'b0, 4'hF, 5'd4, 32'h0));

    // Reset with both masters requesting, then release.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_output("rst_stb", {31'd0, s_stb_o}, 32'd0);
    check_output("rst_ack0", {31'd0, m0_ack_o}, 32'd0);
    check_output("rst_ack1", {31'd0, m1_ack_o}, 32'd0);
    check_output("rst_gnt", {30'd0, gnt_o}, 32'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check_output("rst_release_gnt", {30'd0, gnt_o}, 32'd1);
    drive_master(0, 1'b0, rand_op());
    drive_master(1, 1'b0, rand_op());
    repeat (2) @(posedge clk_i);
    #1 check_output("rst_abort_idle", {30'd0, gnt_o}, 32'd0);

    ops1.push_back(mk_op(1'b1, 4'hF, 5'h10, 32'hDEADBEEF));
    ops1.push_back(mk_op(1'b0, 4'hF, 5'h10, 32'h0));
    apply_stimulus("m1_wr_rd");
    check_output("m1_rd_const", last_rd_data, 32'hDEADBEEF);

    ops0.push_back(mk_op(1'b1, 4'hF, 5'd5, 32'h11223344));
    ops0.push_back(mk_op(1'b1, 4'h2, 5'd5, 32'h0000AB00));
    ops0.push_back(mk_op(1'b0, 4'hF, 5'd5, 32'h0));
    apply_stimulus("byte_wr");
    check_output("byte_rd_const", last_rd_data, 32'h1122AB44);

    for (int k = 0; k < 4; k++) begin
      ops0.push_back(mk_op(1'b0, 4'hF, 5'(k), 32'h0));
      ops1.push_back(mk_op(1'b0, 4'hF, 5'(k + 8), 32'h0));
    end
    apply_stimulus("b2b_rd");

    // Abort: m1 drops stb in its first granted cycle; last grant must not move.
    @(posedge clk_i); #1;
    drive_master(1, 1'b1, mk_op(1'b0, 4'hF, 5'd7, 32'h0));
    @(posedge clk_i); #1;
    check_output("abort_gnt", {30'd0, gnt_o}, 32'd2);
    drive_master(1, 1'b0, rand_op());
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check_output("abort_ack1", {31'd0, m1_ack_o}, 32'd0);
      if (k == 1) check_output("abort_idle", {30'd0, gnt_o}, 32'd0);
      @(posedge clk_i); #1;
    end
    ops0.push_back(mk_op(1'b1, 4'hF, 5'd20, $urandom));
    ops1.push_back(mk_op(1'b1, 4'hF, 5'd21, $urandom));
    apply_stimulus("post_abort");

    // Reset while m0 holds the grant for a read.
    @(posedge clk_i); #1;
    drive_master(0, 1'b1, mk_op(1'b0, 4'hF, 5'd5, 32'h0));
    @(posedge clk_i); #1;
    check_output("rstmid_gnt", {30'd0, gnt_o}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check_output("rstmid_stb", {31'd0, s_stb_o}, 32'd0);
    check_output("rstmid_gnt0", {30'd0, gnt_o}, 32'd0);
    check_output("rstmid_ack0", {31'd0, m0_ack_o}, 32'd0);
    @(negedge clk_i);
    check_output("rstmid_ack0_held", {31'd0, m0_ack_o}, 32'd0);
    drive_master(0, 1'b0, rand_op());
    rst_ni = 1'b1;
    ref_last = 1;
    @(posedge clk_i); #1;
    check_output("rstmid_idle", {30'd0, gnt_o}, 32'd0);

    for (int r = 0; r < 40; r++) begin
      int pat;
      pat = $urandom_range(1, 3);
      if (pat != 2) repeat ($urandom_range(1, 3)) ops0.push_back(rand_op());
      if (pat != 1) repeat ($urandom_range(1, 3)) ops1.push_back(rand_op());
      apply_stimulus("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
